// File: rtl/irq_pkg.sv
// Shared types and constants for the external-interrupt controller.
package irq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_SVC  = 2'd2
  } irq_state_e;

  localparam logic [1:0] ADDR_ENABLE  = 2'd0;
  localparam logic [1:0] ADDR_MODE    = 2'd1;
  localparam logic [1:0] ADDR_PENDING = 2'd2;
  localparam logic [1:0] ADDR_STATUS  = 2'd3;

  localparam int unsigned RDATA_W          = 32;
  localparam int unsigned STATUS_STATE_LSB = 0;
  localparam int unsigned STATUS_ID_LSB    = 8;

endpackage

// File: rtl/irq_sync_edge.sv
// Two-flop synchroniser for one async line, plus a previous-value flop for rise detection.
module irq_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic lvl,
  output logic rise
);

  logic s1_q, s2_q, prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      s1_q   <= d;
      s2_q   <= s1_q;
      prev_q <= s2_q;
    end
  end

  assign lvl  = s2_q;
  assign rise = s2_q & ~prev_q;

endmodule

// File: rtl/ext_irq_ctrl.sv
// External-interrupt controller: per-channel capture, masking, fixed priority and
// a request/ack/eoi handshake keeping a single interrupt in flight.
module ext_irq_ctrl #(
  parameter int unsigned N_CH = 31,
  parameter int unsigned ID_W = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic [N_CH-1:0]   i_ext,
  input  logic              cfg_we,
  input  logic              cfg_re,
  input  logic [1:0]        cfg_addr,
  input  logic [N_CH-1:0]   cfg_wdata,
  output logic [31:0]       cfg_rdata,
  output logic              o_irq,
  output logic [ID_W-1:0]   o_irq_id,
  input  logic              i_irq_ack,
  input  logic              i_irq_eoi
);
  import irq_pkg::*;

  localparam int unsigned ELIG_W = 32'd1 << ID_W;

  irq_state_e          state_q, state_d;
  logic [N_CH-1:0]     lvl, rise;
  logic [N_CH-1:0]     enable_q, mode_q, pend_q, pend_d;
  logic [N_CH-1:0]     elig, mode_chg, pend_clr;
  logic [ELIG_W-1:0]   elig_x;
  logic [ID_W-1:0]     win_id, id_d;
  logic                irq_d, any_elig, ack_fire;
  logic                en_wr, mode_wr, pend_wr;
  logic [RDATA_W-1:0]  rdata_d, status;

  for (genvar g = 0; g < N_CH; g++) begin : g_sync
    irq_sync_edge u_sync (
      .clk   (Clk),
      .rst_n (Rst),
      .d     (i_ext[g]),
      .lvl   (lvl[g]),
      .rise  (rise[g])
    );
  end

  assign en_wr    = cfg_we && (cfg_addr == ADDR_ENABLE);
  assign mode_wr  = cfg_we && (cfg_addr == ADDR_MODE);
  assign pend_wr  = cfg_we && (cfg_addr == ADDR_PENDING);
  assign mode_chg = mode_wr ? (mode_q ^ cfg_wdata) : '0;

  assign elig     = pend_q & enable_q;
  assign elig_x   = ELIG_W'(elig);
  assign any_elig = |elig;

  // Lowest index wins: scan from the top so the last hit is the smallest.
  always_comb begin
    win_id = '0;
    for (int i = int'(N_CH) - 1; i >= 0; i--) begin
      if (elig[i]) win_id = ID_W'(i);
    end
  end

  always_comb begin
    pend_clr = '0;
    for (int i = 0; i < int'(N_CH); i++) begin
      pend_clr[i] = (ack_fire && (o_irq_id == ID_W'(i))) || (pend_wr && cfg_wdata[i]);
    end
  end

  // Edge channels: a rise beats any clear landing in the same cycle.
  always_comb begin
    pend_d = pend_q;
    for (int i = 0; i < int'(N_CH); i++) begin
      if (mode_chg[i])       pend_d[i] = 1'b0;
      else if (!mode_q[i])   pend_d[i] = lvl[i];
      else if (rise[i])      pend_d[i] = 1'b1;
      else if (pend_clr[i])  pend_d[i] = 1'b0;
    end
  end

  always_comb begin
    state_d  = state_q;
    irq_d    = 1'b0;
    id_d     = o_irq_id;
    ack_fire = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (any_elig) begin
          state_d = ST_REQ;
          irq_d   = 1'b1;
          id_d    = win_id;
        end
      end
      ST_REQ: begin
        if (i_irq_ack) begin
          ack_fire = 1'b1;
          state_d  = ST_SVC;
        end else if (!elig_x[o_irq_id]) begin
          state_d = ST_IDLE;
        end else begin
          irq_d = 1'b1;
        end
      end
      ST_SVC: begin
        if (i_irq_eoi) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    status = '0;
    status[STATUS_STATE_LSB +: 2]  = state_q;
    status[STATUS_ID_LSB +: ID_W] = o_irq_id;
  end

  always_comb begin
    rdata_d = '0;
    unique case (cfg_addr)
      ADDR_ENABLE:  rdata_d = RDATA_W'(enable_q);
      ADDR_MODE:    rdata_d = RDATA_W'(mode_q);
      ADDR_PENDING: rdata_d = RDATA_W'(pend_q);
      ADDR_STATUS:  rdata_d = status;
      default:      rdata_d = '0;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q   <= ST_IDLE;
      o_irq     <= 1'b0;
      o_irq_id  <= '0;
      enable_q  <= '0;
      mode_q    <= '0;
      pend_q    <= '0;
      cfg_rdata <= '0;
    end else begin
      state_q  <= state_d;
      o_irq    <= irq_d;
      o_irq_id <= id_d;
      pend_q   <= pend_d;
      if (en_wr)   enable_q  <= cfg_wdata;
      if (mode_wr) mode_q    <= cfg_wdata;
      if (cfg_re)  cfg_rdata <= rdata_d;
    end
  end

endmodule

// File: tb/tb_ext_irq_ctrl.sv
// Scoreboard bench for ext_irq_ctrl: directed stimulus queues expected reads and
// request ids; a negedge monitor pops and compares them as the DUT presents them.
module tb_ext_irq_ctrl;
  localparam int unsigned N   = 31;
  localparam int unsigned IDW = 5;

  logic            Clk = 1'b0;
  logic            Rst = 1'b0;
  logic [N-1:0]    ext = '0;
  logic            cfg_we = 1'b0, cfg_re = 1'b0;
  logic [1:0]      cfg_addr = 2'd0;
  logic [N-1:0]    cfg_wdata = '0;
  logic [31:0]     cfg_rdata;
  logic            o_irq;
  logic [IDW-1:0]  o_irq_id;
  logic            ack = 1'b0, eoi = 1'b0;

  logic [3:0]      ext4 = '0;
  logic            we4 = 1'b0, re4 = 1'b0;
  logic [1:0]      addr4 = 2'd0;
  logic [3:0]      wdata4 = '0;
  logic [31:0]     rdata4;
  logic            irq4;
  logic [1:0]      id4;

  int n_vec  = 0;
  int n_miss = 0;

  logic [31:0]    rd_q[$];
  logic [IDW-1:0] irq_q[$];

  always #5 Clk = ~Clk;

  ext_irq_ctrl #(.N_CH(N)) dut (
    .Clk(Clk), .Rst(Rst), .i_ext(ext),
    .cfg_we(cfg_we), .cfg_re(cfg_re), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
    .cfg_rdata(cfg_rdata), .o_irq(o_irq), .o_irq_id(o_irq_id),
    .i_irq_ack(ack), .i_irq_eoi(eoi)
  );

  ext_irq_ctrl #(.N_CH(4)) dut4 (
    .Clk(Clk), .Rst(Rst), .i_ext(ext4),
    .cfg_we(we4), .cfg_re(re4), .cfg_addr(addr4), .cfg_wdata(wdata4),
    .cfg_rdata(rdata4), .o_irq(irq4), .o_irq_id(id4),
    .i_irq_ack(1'b0), .i_irq_eoi(1'b0)
  );

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endfunction

  // Monitor: read data one cycle after cfg_re, request id on every o_irq rise.
  logic re_d;
  logic irq_prev = 1'b0;
  always @(posedge Clk or negedge Rst) begin
    if (!Rst) re_d <= 1'b0;
    else      re_d <= cfg_re;
  end

  always @(negedge Clk) begin
    if (!Rst) begin
      irq_prev = 1'b0;
    end else begin
      if (re_d) begin
        if (rd_q.size() == 0) begin
          n_vec++; n_miss++;
          $display("FAIL rd_unexpected: got 0x%0h, no read queued", cfg_rdata);
        end else begin
          check("cfg_rdata", cfg_rdata, rd_q.pop_front());
        end
      end
      if (o_irq && !irq_prev) begin
        if (irq_q.size() == 0) begin
          n_vec++; n_miss++;
          $display("FAIL irq_unexpected: got id %0d, no request expected", o_irq_id);
        end else begin
          check("irq_id", 32'(o_irq_id), 32'(irq_q.pop_front()));
        end
      end
      irq_prev = o_irq;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge Clk);
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    cfg_we = 1'b1; cfg_addr = a; cfg_wdata = N'(d);
    @(negedge Clk);
    cfg_we = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, input logic [31:0] exp);
    rd_q.push_back(exp);
    cfg_re = 1'b1; cfg_addr = a;
    @(negedge Clk);
    cfg_re = 1'b0;
  endtask

  task automatic wait_irq(input int max, output int cyc);
    cyc = 0;
    for (int i = 1; i <= max; i++) begin
      @(negedge Clk);
      if (o_irq) begin
        cyc = i;
        break;
      end
    end
    if (cyc == 0) begin
      n_vec++; n_miss++;
      $display("FAIL irq_timeout: o_irq still 0 after %0d cycles, expected 1", max);
    end
  endtask

  task automatic do_ack();
    ack = 1'b1; @(negedge Clk); ack = 1'b0;
  endtask

  task automatic do_eoi();
    eoi = 1'b1; @(negedge Clk); eoi = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  initial begin
    int c;
    // 1: reset state, level channel, re-request while level stays high
    tick(3);
    check("rst_irq", 32'(o_irq), 32'd0);
    check("rst_id", 32'(o_irq_id), 32'd0);
    check("rst_rdata", cfg_rdata, 32'd0);
    Rst = 1'b1;
    tick(1);
    rd(2'd0, 32'h0);
    rd(2'd1, 32'h0);
    rd(2'd2, 32'h0);
    rd(2'd3, 32'h0);
    wr(2'd0, 32'h0E);
    rd(2'd0, 32'h0E);
    irq_q.push_back(5'd3);
    ext[3] = 1'b1;
    wait_irq(6, c);
    check("t1_latency", 32'(c), 32'd4);
    rd(2'd3, 32'h301);
    do_ack();
    rd(2'd3, 32'h302);
    rd(2'd2, 32'h08);
    irq_q.push_back(5'd3);
    do_eoi();
    wait_irq(4, c);
    check("t1_eoi_gap", 32'(c), 32'd1);
    wr(2'd0, 32'h0);
    tick(2);
    check("t1_drop", 32'(o_irq), 32'd0);
    rd(2'd3, 32'h300);
    ext[3] = 1'b0;
    tick(4);
    rd(2'd2, 32'h0);

    // 2: edge capture, ack clears, short pulse between edges is lost
    wr(2'd1, 32'h02);
    wr(2'd0, 32'h02);
    irq_q.push_back(5'd1);
    ext[1] = 1'b1;
    tick(1);
    ext[1] = 1'b0;
    wait_irq(6, c);
    rd(2'd2, 32'h02);
    do_ack();
    rd(2'd2, 32'h0);
    do_eoi();
    tick(4);
    check("t2_no_rereq", 32'(o_irq), 32'd0);
    ext[1] = 1'b1;
    #4;
    ext[1] = 1'b0;
    @(negedge Clk);
    tick(4);
    rd(2'd2, 32'h0);
    check("t2_short_pulse", 32'(o_irq), 32'd0);

    // 3: simultaneous edges, priority, one-cycle idle gap after eoi
    wr(2'd1, 32'h106);
    wr(2'd0, 32'h104);
    irq_q.push_back(5'd2);
    irq_q.push_back(5'd8);
    ext[2] = 1'b1;
    ext[8] = 1'b1;
    wait_irq(6, c);
    rd(2'd2, 32'h104);
    do_ack();
    do_eoi();
    check("t3_gap_idle", 32'(o_irq), 32'd0);
    tick(1);
    check("t3_next_req", 32'(o_irq), 32'd1);
    do_ack();
    do_eoi();
    ext[2] = 1'b0;
    ext[8] = 1'b0;
    tick(3);
    rd(2'd2, 32'h0);

    // 4: new edge in the same cycle as its ack keeps pending set
    irq_q.push_back(5'd2);
    ext[2] = 1'b1;
    wait_irq(6, c);
    ext[2] = 1'b0;
    tick(3);
    ext[2] = 1'b1;
    tick(2);
    do_ack();
    rd(2'd2, 32'h04);
    irq_q.push_back(5'd2);
    do_eoi();
    wait_irq(4, c);
    do_ack();
    rd(2'd2, 32'h0);
    do_eoi();

    // 5: asynchronous reset in REQ
    ext[2] = 1'b0;
    tick(3);
    irq_q.push_back(5'd2);
    ext[2] = 1'b1;
    wait_irq(6, c);
    rd(2'd3, 32'h201);
    #2;
    Rst = 1'b0;
    #1;
    check("t5_irq", 32'(o_irq), 32'd0);
    check("t5_id", 32'(o_irq_id), 32'd0);
    check("t5_rdata", cfg_rdata, 32'd0);
    tick(2);
    Rst = 1'b1;
    ext[2] = 1'b0;
    rd(2'd3, 32'h0);
    rd(2'd0, 32'h0);

    // 6: bits above N_CH read zero
    wr(2'd0, 32'hFFFF_FFFF);
    rd(2'd0, 32'h7FFF_FFFF);
    wr(2'd0, 32'h0);
    begin
      logic [31:0] all_ones;
      all_ones = 32'hFFFF_FFFF;
      we4 = 1'b1; addr4 = 2'd0; wdata4 = all_ones[3:0];
      @(negedge Clk);
      we4 = 1'b0; re4 = 1'b1;
      @(negedge Clk);
      re4 = 1'b0;
      check("t6_enable4", rdata4, 32'h0000_000F);
      addr4 = 2'd3; re4 = 1'b1;
      @(negedge Clk);
      re4 = 1'b0;
      check("t6_status4", rdata4, 32'h0);
    end

    tick(3);
    check("rd_q_drained", 32'(rd_q.size()), 32'd0);
    check("irq_q_drained", 32'(irq_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
